// File: rtl/bk_carry_sum_pipe_if.sv
// bk_carry_sum_pipe_if: p/g/cin request and sum/flag result handshake bundle
interface bk_carry_sum_pipe_if #(parameter int WIDTH = 8);
  logic in_valid, in_ready, cin, out_valid, out_ready, cout, ovf, zero;
  logic [WIDTH-1:0] p, g, sum;
  modport master (output in_valid, p, g, cin, out_ready, input in_ready, out_valid, sum, cout, ovf, zero);
  modport slave (input in_valid, p, g, cin, out_ready, output in_ready, out_valid, sum, cout, ovf, zero);
endinterface

// File: rtl/bk_carry_sum_pipe.sv
// bk_carry_sum_pipe: three-stage Brent-Kung carry tree finishing a+b+cin from p/g
module bk_carry_sum_pipe #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst,
  bk_carry_sum_pipe_if.slave bus
);
  localparam int L = $clog2(WIDTH);
  logic adv;
  logic v1_q, v2_q, v3_q, cin1_q, cin2_q, cout_q, ovf_q, zero_q;
  logic [WIDTH-1:0] p1_q, gu_q, pu_q, p2_q, c_q, sum_q;
  logic [WIDTH-1:0] gu_d, pu_d, c_d, pt, sum_d;
  assign adv = ~v3_q | bus.out_ready;
  assign bus.in_ready = adv & ~rst;
  assign bus.out_valid = v3_q;
  assign bus.sum = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf = ovf_q;
  assign bus.zero = zero_q;
  // S1: fold cin into bit 0, then up-sweep spans 2 and 4 in place
  always_comb begin
    gu_d = bus.g;
    gu_d[0] = bus.g[0] | (bus.p[0] & bus.cin);
    pu_d = bus.p;
    for (int k = 1; k <= 2; k++)
      for (int i = (1 << k) - 1; i < WIDTH; i += (1 << k)) begin
        gu_d[i] = gu_d[i] | (pu_d[i] & gu_d[i - (1 << (k - 1))]);
        pu_d[i] = pu_d[i] & pu_d[i - (1 << (k - 1))];
      end
  end
  // S2: finish the up-sweep, then down-sweep so every bit holds G[i:0]
  always_comb begin
    c_d = gu_q;
    pt = pu_q;
    for (int k = 3; k <= L; k++)
      for (int i = (1 << k) - 1; i < WIDTH; i += (1 << k)) begin
        c_d[i] = c_d[i] | (pt[i] & c_d[i - (1 << (k - 1))]);
        pt[i] = pt[i] & pt[i - (1 << (k - 1))];
      end
    for (int k = L - 1; k >= 1; k--)
      for (int i = (1 << k) + (1 << (k - 1)) - 1; i < WIDTH; i += (1 << k))
        c_d[i] = c_d[i] | (pt[i] & c_d[i - (1 << (k - 1))]);
  end
  assign sum_d = p2_q ^ {c_q[WIDTH-2:0], cin2_q};
  // all stages advance together on adv and hold otherwise; reset clears everything
  always_ff @(posedge clk)
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      p1_q <= '0;
      cin1_q <= 1'b0;
      gu_q <= '0;
      pu_q <= '0;
      p2_q <= '0;
      cin2_q <= 1'b0;
      c_q <= '0;
      sum_q <= '0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      v1_q <= bus.in_valid;
      p1_q <= bus.p;
      cin1_q <= bus.cin;
      gu_q <= gu_d;
      pu_q <= pu_d;
      v2_q <= v1_q;
      p2_q <= p1_q;
      cin2_q <= cin1_q;
      c_q <= c_d;
      v3_q <= v2_q;
      sum_q <= sum_d;
      cout_q <= c_q[WIDTH-1];
      ovf_q <= c_q[WIDTH-2] ^ c_q[WIDTH-1];
      zero_q <= ~|sum_d;
    end
endmodule

// File: tb/tb_bk_carry_sum_pipe.sv
// tb_bk_carry_sum_pipe: directed and random scoreboard bench for bk_carry_sum_pipe
module tb_bk_carry_sum_pipe;
  localparam int W = 8;
  typedef struct packed {logic [W-1:0] sum; logic cout, ovf, zero;} res_t;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  bk_carry_sum_pipe_if #(.WIDTH(W)) bus();
  bk_carry_sum_pipe #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  res_t q[$];
  res_t e;
  int n_chk = 0, n_fail = 0, n_acc = 0, n_out = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic res_t model(input logic [W-1:0] pv, input logic [W-1:0] gv, input logic c);
    logic [W-1:0] a, b, a_lo, b_lo, t;
    logic [W:0] s;
    res_t r;
    a = pv | gv;
    b = gv;
    a_lo = a;
    b_lo = b;
    a_lo[W-1] = 1'b0;
    b_lo[W-1] = 1'b0;
    t = a_lo + b_lo + W'(c);
    s = {1'b0, a} + {1'b0, b} + (W+1)'(c);
    r.sum = s[W-1:0];
    r.cout = s[W];
    r.ovf = t[W-1] ^ s[W];
    r.zero = (s[W-1:0] == '0);
    return r;
  endfunction
  // scoreboard: push on accept, pop and compare on transfer, flush on reset
  always @(negedge clk)
    if (rst) q.delete();
    else begin
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(bus.p, bus.g, bus.cin));
        n_acc++;
      end
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (q.size() == 0) chk("spurious_out", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("sb_sum", 32'(bus.sum), 32'(e.sum));
          chk("sb_cout", 32'(bus.cout), 32'(e.cout));
          chk("sb_ovf", 32'(bus.ovf), 32'(e.ovf));
          chk("sb_zero", 32'(bus.zero), 32'(e.zero));
        end
      end
    end
  task automatic send(input logic [W-1:0] pv, input logic [W-1:0] gv, input logic c);
    bit ok;
    ok = 0;
    bus.p = pv;
    bus.g = gv;
    bus.cin = c;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask
  task automatic expect_out(input string tag, input logic [W-1:0] s, input logic co, input logic ov, input logic z);
    int cnt;
    cnt = 0;
    while (cnt < 20) begin
      @(negedge clk);
      cnt++;
      if (bus.out_valid) break;
    end
    chk({tag, "_latency"}, 32'(cnt), 32'd3);
    chk({tag, "_sum"}, 32'(bus.sum), 32'(s));
    chk({tag, "_cout"}, 32'(bus.cout), 32'(co));
    chk({tag, "_ovf"}, 32'(bus.ovf), 32'(ov));
    chk({tag, "_zero"}, 32'(bus.zero), 32'(z));
    @(negedge clk);
    chk({tag, "_one_cycle"}, 32'(bus.out_valid), 32'd0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [W-1:0] ra, rb;
    int cnt;
    bus.in_valid = 1'b0;
    bus.p = '0;
    bus.g = '0;
    bus.cin = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sum", 32'(bus.sum), 32'd0);
    chk("rst_flags", {29'd0, bus.cout, bus.ovf, bus.zero}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    send(8'h0E, 8'h01, 1'b0);
    expect_out("t1", 8'h10, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    send(8'hFF, 8'h00, 1'b1);
    expect_out("t2", 8'h00, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    send(8'h7E, 8'h01, 1'b0);
    expect_out("t3", 8'h80, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    send(8'h00, 8'h80, 1'b0);
    expect_out("t4", 8'h00, 1'b1, 1'b1, 1'b1);
    // back-to-back words with a two-cycle output stall
    @(posedge clk);
    #1 bus.in_valid = 1'b1; bus.p = 8'h00; bus.g = 8'h01; bus.cin = 1'b0;
    @(negedge clk);
    chk("b2b_acc1", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.p = 8'h30; bus.g = 8'h00;
    @(negedge clk);
    chk("b2b_acc2", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.p = 8'hFE; bus.g = 8'h01;
    @(negedge clk);
    chk("b2b_acc3", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_sum", 32'(bus.sum), 32'h02);
      chk("stall_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("b2b_r1", 32'(bus.sum), 32'h02);
    @(negedge clk);
    chk("b2b_r2", 32'(bus.sum), 32'h30);
    @(negedge clk);
    chk("b2b_r3", {23'd0, bus.cout, bus.sum}, 32'h100);
    @(negedge clk);
    chk("b2b_drained", 32'(bus.out_valid), 32'd0);
    // reset with two words in flight
    @(posedge clk);
    #1 bus.in_valid = 1'b1; bus.p = 8'h05; bus.g = 8'h00;
    @(posedge clk);
    #1 bus.p = 8'h0A;
    @(posedge clk);
    #1 bus.in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("flush_ready_in_rst", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_outputs", {28'd0, bus.cout, bus.ovf, bus.zero, |bus.sum}, 32'd0);
    chk("flush_ready_after", 32'(bus.in_ready), 32'd1);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) cnt++;
    end
    chk("flush_no_output", 32'(cnt), 32'd0);
    // random traffic against the scoreboard
    @(posedge clk);
    #1 n_acc = 0; n_out = 0;
    for (int i = 0; i < 10000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      bus.p = ra ^ rb;
      bus.g = ra & rb;
      bus.cin = 1'($urandom_range(0, 1));
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rand_queue_empty", 32'(q.size()), 32'd0);
    chk("rand_count", 32'(n_out), 32'(n_acc));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
